// File: rtl/ls_sequencer_if.sv
// Decode, data-memory and register-writeback signals of the LW/SW sequencer.
// master = sequencer side, slave = decode/memory/regfile side.
interface ls_sequencer_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  logic        reg_we;
  logic [4:0]  reg_waddr;
  logic [31:0] reg_wdata;

  logic        done;
  logic        err;
  logic [1:0]  err_code;

  modport master (
    input  instr_valid, instr, rs_data, rt_data, mem_ack, mem_rdata,
    output instr_ready, mem_req, mem_we, mem_addr, mem_wdata,
           reg_we, reg_waddr, reg_wdata, done, err, err_code
  );

  modport slave (
    output instr_valid, instr, rs_data, rt_data, mem_ack, mem_rdata,
    input  instr_ready, mem_req, mem_we, mem_addr, mem_wdata,
           reg_we, reg_waddr, reg_wdata, done, err, err_code
  );
endinterface

// File: rtl/ls_sequencer.sv
// MIPS32 LW/SW sequencer: LW done 4 cycles after accept, SW 3, +1 per memory wait cycle.
// Accepts only in IDLE (instr_ready); mem_req held until mem_ack or TIMEOUT cycles.
module ls_sequencer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  ls_sequencer_if.master bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_MEM  = 3'd2;
  localparam logic [2:0] S_WB   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  localparam logic [5:0] OP_LW = 6'h23;
  localparam logic [5:0] OP_SW = 6'h2B;

  // Last wait-cycle index; an unacked MEM cycle at this count aborts.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic [2:0]  state;
  logic [5:0]  opcode_q;
  logic [4:0]  rt_q;
  logic [15:0] imm_q;
  logic [31:0] rs_data_q;
  logic [31:0] rt_data_q;
  logic [31:0] addr_q;
  logic [31:0] rdata_q;
  logic [7:0]  cnt_q;
  logic [1:0]  err_code_q;

  logic [31:0] ea;
  logic        is_lw;
  logic        is_sw;
  logic        unused_rs_field;

  assign ea    = rs_data_q + {{16{imm_q[15]}}, imm_q};
  assign is_lw = (opcode_q == OP_LW);
  assign is_sw = (opcode_q == OP_SW);

  // The base register arrives already read out, so the rs index is not needed here.
  assign unused_rs_field = ^bus.instr[25:21];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      opcode_q   <= '0;
      rt_q       <= '0;
      imm_q      <= '0;
      rs_data_q  <= '0;
      rt_data_q  <= '0;
      addr_q     <= '0;
      rdata_q    <= '0;
      cnt_q      <= '0;
      err_code_q <= 2'b00;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.instr_valid) begin
            opcode_q   <= bus.instr[31:26];
            rt_q       <= bus.instr[20:16];
            imm_q      <= bus.instr[15:0];
            rs_data_q  <= bus.rs_data;
            rt_data_q  <= bus.rt_data;
            err_code_q <= 2'b00;
            state      <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (!is_lw && !is_sw) begin
            err_code_q <= 2'b01;
            state      <= S_ERR;
          end else if (ea[1:0] != 2'b00) begin
            err_code_q <= 2'b10;
            state      <= S_ERR;
          end else begin
            addr_q <= ea;
            cnt_q  <= '0;
            state  <= S_MEM;
          end
        end
        S_MEM: begin
          // An ack on the final allowed cycle still completes normally.
          if (bus.mem_ack) begin
            rdata_q <= bus.mem_rdata;
            state   <= is_lw ? S_WB : S_DONE;
          end else if (cnt_q == TO_LAST) begin
            err_code_q <= 2'b11;
            state      <= S_ERR;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_WB:    state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.instr_ready = (state == S_IDLE);
  assign bus.mem_req     = (state == S_MEM);
  assign bus.mem_we      = (state == S_MEM) && is_sw;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_wdata   = ((state == S_MEM) && is_sw) ? rt_data_q : 32'h0;
  assign bus.reg_we      = (state == S_WB) && (rt_q != 5'd0);
  assign bus.reg_waddr   = rt_q;
  assign bus.reg_wdata   = rdata_q;
  assign bus.done        = (state == S_DONE) || (state == S_ERR);
  assign bus.err         = (state == S_ERR);
  assign bus.err_code    = err_code_q;

endmodule

// File: tb/tb_ls_sequencer.sv
// Directed vector table for ls_sequencer (TIMEOUT=4) plus a mid-transaction reset sequence.
module tb_ls_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ls_sequencer_if bus ();

  ls_sequencer #(.TIMEOUT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] rdata;
    int          waits;       // unacked MEM cycles before ack; 255 = never ack
    logic [31:0] e_addr;
    logic        e_we;
    logic [31:0] e_wdata;
    int          e_req;       // number of cycles mem_req is high
    int          e_regwe_cyc; // 0 = no reg_we expected
    logic [4:0]  e_waddr;
    logic [31:0] e_regdata;
    int          e_done;
    logic        e_err;
    logic [1:0]  e_code;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs[NV];

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  vec_t        v;
  int          cyc, req_cnt, waits_seen, regwe_cyc, done_cyc;
  logic [31:0] got_addr, got_wdata, got_regdata;
  logic        got_we, got_err, first, unstable;
  logic [4:0]  got_waddr;
  logic [1:0]  got_code;
  int          seen_bad;

  initial begin
    //           instr         rs_data       rt_data       rdata       waits addr          we    wdata        req regwe waddr  regdata       done err  code
    vecs[0] = '{32'h8C220004, 32'h00001000, 32'h0,        32'hDEADBEEF, 0, 32'h00001004, 1'b0, 32'h0,        1, 3, 5'd2, 32'hDEADBEEF, 4, 1'b0, 2'b00};
    vecs[1] = '{32'hAC43FFFC, 32'h00002000, 32'h12345678, 32'h0,        3, 32'h00001FFC, 1'b1, 32'h12345678, 4, 0, 5'd0, 32'h0,        6, 1'b0, 2'b00};
    vecs[2] = '{32'h8C220000, 32'h00001001, 32'h0,        32'h0,        0, 32'h0,        1'b0, 32'h0,        0, 0, 5'd0, 32'h0,        2, 1'b1, 2'b10};
    vecs[3] = '{32'h00220001, 32'h00001000, 32'h0,        32'h0,        0, 32'h0,        1'b0, 32'h0,        0, 0, 5'd0, 32'h0,        2, 1'b1, 2'b01};
    vecs[4] = '{32'hAC430010, 32'h00003000, 32'hA5A5A5A5, 32'h0,      255, 32'h00003010, 1'b1, 32'hA5A5A5A5, 4, 0, 5'd0, 32'h0,        6, 1'b1, 2'b11};
    vecs[5] = '{32'h8C250008, 32'h00004000, 32'h0,        32'hCAFEF00D, 3, 32'h00004008, 1'b0, 32'h0,        4, 6, 5'd5, 32'hCAFEF00D, 7, 1'b0, 2'b00};
    vecs[6] = '{32'h8C200000, 32'h00005000, 32'h0,        32'h11111111, 1, 32'h00005000, 1'b0, 32'h0,        2, 0, 5'd0, 32'h0,        5, 1'b0, 2'b00};
    vecs[7] = '{32'h8C270008, 32'hFFFFFFFC, 32'h0,        32'h0BADF00D, 0, 32'h00000004, 1'b0, 32'h0,        1, 3, 5'd7, 32'h0BADF00D, 4, 1'b0, 2'b00};
    vecs[8] = '{32'hAC298000, 32'h00010000, 32'h55AA55AA, 32'h0,        1, 32'h00008000, 1'b1, 32'h55AA55AA, 2, 0, 5'd0, 32'h0,        4, 1'b0, 2'b00};
    vecs[9] = '{32'h80220004, 32'h00001000, 32'h0,        32'h0,        0, 32'h0,        1'b0, 32'h0,        0, 0, 5'd0, 32'h0,        2, 1'b1, 2'b01};

    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    bus.rs_data     = '0;
    bus.rt_data     = '0;
    bus.mem_ack     = 1'b0;
    bus.mem_rdata   = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ready",    bus.instr_ready, 1);
    chk("rst_mem_req",  bus.mem_req, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_reg_we",   bus.reg_we, 0);
    chk("rst_done",     bus.done, 0);
    chk("rst_err_code", bus.err_code, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      @(negedge clk);
      chk($sformatf("v%0d_ready_idle", i), bus.instr_ready, 1);
      bus.instr_valid = 1'b1;
      bus.instr       = v.instr;
      bus.rs_data     = v.rs_data;
      bus.rt_data     = v.rt_data;
      @(negedge clk);
      // Scramble the offer after the accept edge; the sequencer must use its captured copy.
      bus.instr_valid = 1'b0;
      bus.instr       = 32'hFFFFFFFF;
      bus.rs_data     = 32'h0000_0003;
      bus.rt_data     = 32'hEEEE_EEEE;
      cyc = 1; req_cnt = 0; waits_seen = 0; regwe_cyc = 0; done_cyc = 0;
      first = 1'b1; unstable = 1'b0;
      got_addr = '0; got_we = 1'b0; got_wdata = '0; got_waddr = '0; got_regdata = '0;
      got_err = 1'b0; got_code = 2'b00;
      while (cyc <= 20 && done_cyc == 0) begin
        if (cyc == 1) chk($sformatf("v%0d_ready_busy", i), bus.instr_ready, 0);
        if (bus.mem_req) begin
          req_cnt++;
          if (first) begin
            got_addr = bus.mem_addr; got_we = bus.mem_we; got_wdata = bus.mem_wdata; first = 1'b0;
          end else if (bus.mem_addr !== got_addr || bus.mem_we !== got_we || bus.mem_wdata !== got_wdata) begin
            unstable = 1'b1;
          end
          if (waits_seen == v.waits) begin
            bus.mem_ack = 1'b1; bus.mem_rdata = v.rdata;
          end else begin
            bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0BAD0BAD; waits_seen++;
          end
        end else begin
          // Stray acks outside MEM must have no effect.
          bus.mem_ack = 1'b1; bus.mem_rdata = 32'hBADBAD00;
        end
        if (bus.reg_we) begin
          regwe_cyc = cyc; got_waddr = bus.reg_waddr; got_regdata = bus.reg_wdata;
        end
        if (bus.done) begin
          done_cyc = cyc; got_err = bus.err; got_code = bus.err_code;
        end
        @(negedge clk);
        cyc++;
      end
      bus.mem_ack = 1'b0;
      chk($sformatf("v%0d_req_cycles", i), req_cnt, v.e_req);
      if (v.e_req > 0) begin
        chk($sformatf("v%0d_mem_addr", i),  got_addr, v.e_addr);
        chk($sformatf("v%0d_mem_we", i),    got_we, v.e_we);
        chk($sformatf("v%0d_mem_wdata", i), got_wdata, v.e_wdata);
        chk($sformatf("v%0d_mem_stable", i), unstable, 0);
      end
      chk($sformatf("v%0d_regwe_cycle", i), regwe_cyc, v.e_regwe_cyc);
      if (v.e_regwe_cyc > 0) begin
        chk($sformatf("v%0d_reg_waddr", i), got_waddr, v.e_waddr);
        chk($sformatf("v%0d_reg_wdata", i), got_regdata, v.e_regdata);
      end
      chk($sformatf("v%0d_done_cycle", i), done_cyc, v.e_done);
      chk($sformatf("v%0d_err", i),        got_err, v.e_err);
      chk($sformatf("v%0d_err_code", i),   got_code, v.e_code);
      chk($sformatf("v%0d_done_pulse", i), bus.done, 0);
      chk($sformatf("v%0d_code_held", i),  bus.err_code, v.e_code);
    end

    // Reset in the middle of a memory request: everything drops at once, nothing follows.
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr       = 32'h8C220004;
    bus.rs_data     = 32'h00001000;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    bus.mem_ack     = 1'b0;
    cyc = 0;
    while (!bus.mem_req && cyc < 5) begin
      @(negedge clk);
      cyc++;
    end
    chk("mid_reset_req_seen", bus.mem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_reset_mem_req", bus.mem_req, 0);
    chk("mid_reset_reg_we",  bus.reg_we, 0);
    chk("mid_reset_done",    bus.done, 0);
    chk("mid_reset_ready",   bus.instr_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'h77777777;
    seen_bad = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.done || bus.reg_we || bus.mem_req) seen_bad++;
    end
    bus.mem_ack = 1'b0;
    chk("post_reset_quiet", seen_bad, 0);
    chk("post_reset_ready", bus.instr_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ls_sequencer.md
Name: ls_sequencer

Overview:
Multi-cycle load/store sequencer for the MIPS32 LW/SW datapath. Accepts one decoded instruction word plus the register-file read data. Forms the effective address as rs + sign-extended imm16, checks word alignment, and drives a req/ack data-memory handshake. For LW it writes the result back to the register file. Sits between the decode stage and the data memory and register file write port.

Parameters:
TIMEOUT, 16, max cycles mem_req may stay high without mem_ack before aborting (1..255)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
instr_valid  in  1  instruction offered
instr_ready  out  1  sequencer can accept
instr  in  32  opcode[31:26], rs[25:21], rt[20:16], imm[15:0]
rs_data  in  32  base register value, valid with instr_valid
rt_data  in  32  store data, valid with instr_valid
mem_req  out  1  memory request, held until ack
mem_we  out  1  1 = write (SW)
mem_addr  out  32  word address (byte address, [1:0]=00)
mem_wdata  out  32  store data
mem_ack  in  1  memory completes request this cycle
mem_rdata  in  32  load data, valid with mem_ack
reg_we  out  1  register write strobe, one cycle
reg_waddr  out  5  destination register (rt)
reg_wdata  out  32  loaded word
done  out  1  one-cycle pulse at end of every accepted instruction
err  out  1  one-cycle pulse with done on abort
err_code  out  2  00 none, 01 illegal opcode, 10 misaligned, 11 timeout; held until next accept

Behaviour:
- Reset (async, rst_n=0): state IDLE, instr_ready=1, all other outputs 0, timeout counter 0. Reset mid-transaction drops mem_req immediately. No writeback or done follows.
- States: IDLE, ADDR, MEM, WB, DONE, ERR.
- IDLE: instr_ready=1. Accept when instr_valid&instr_ready. Register opcode, rt, rs_data, rt_data, imm. Go to ADDR. instr_ready=0 in every other state.
- ADDR (1 cycle): ea = rs_data + {{16{imm[15]}},imm}, mod 2^32, wrap-around ignored. Opcode 6'h23 (LW) or 6'h2B (SW) only; other opcodes go to ERR with code 01. ea[1:0]!=0 goes to ERR with code 10. Opcode check takes priority over alignment. Otherwise register ea into mem_addr and go to MEM.
- MEM: mem_req=1, mem_we=1 for SW, mem_wdata=rt_data for SW, else 0. mem_addr/mem_we/mem_wdata are stable while mem_req=1.
  - mem_ack=1: capture mem_rdata. LW goes to WB, SW goes to DONE. mem_req deasserts the following cycle.
  - Counter increments each MEM cycle without ack. Reaching TIMEOUT goes to ERR with code 11, mem_req drops. An ack in the same cycle the counter reaches TIMEOUT wins (completes normally). Counter clears on MEM entry.
  - mem_ack outside MEM is ignored.
- WB (1 cycle): reg_we=1 only if rt!=0 (writes to $zero suppressed). reg_waddr=rt, reg_wdata=captured word. Then DONE.
- DONE (1 cycle): done=1, err=0, err_code=00. Then IDLE.
- ERR (1 cycle): done=1, err=1, err_code set. No memory access or writeback for codes 01/10. Then IDLE.
- Latency (instr accept edge = cycle 0, zero-wait ack):
  - LW: mem_req cycle 2, reg_we cycle 3, done cycle 4.
  - SW: mem_req cycle 2, done cycle 3.
  - Each wait cycle adds 1.
- Back-to-back: next accept no earlier than the cycle after done (IDLE). Throughput is 1 LW per 5 cycles.
- All outputs are registered or decoded from state only. No combinational input-to-output path except none.

Test Plan:
- Reset: hold rst_n=0 mid-MEM with mem_req=1. Required: mem_req, reg_we, done all 0 asynchronously; instr_ready=1 after release.
- LW, zero wait: instr=0x8C220004 (rs=1, rt=2, imm=4), rs_data=0x00001000, mem_ack in first MEM cycle with mem_rdata=0xDEADBEEF. Required: mem_addr=0x00001004, mem_we=0; reg_we cycle 3 with waddr=2, wdata=0xDEADBEEF; done cycle 4, err=0.
- SW, negative offset, 3 wait cycles: instr=0xAC43FFFC (imm=-4), rs_data=0x00002000, rt_data=0x12345678. Required: mem_addr=0x00001FFC, mem_we=1, mem_wdata=0x12345678; mem_req held 4 cycles; no reg_we; done cycle 6.
- Misaligned: LW with rs_data=0x00001001, imm=0. Required: no mem_req; done=err=1 at cycle 2; err_code=10. Illegal opcode 0x00 also yields err_code=01.
- Timeout: TIMEOUT=4, SW, never ack. Required: mem_req high exactly 4 cycles; err pulse, err_code=11. Separately, ack in the 4th cycle completes normally.
- $zero target: LW with rt=0 and ack. Required: memory read occurs, reg_we stays 0, done pulses.
